// File: rtl/four_step_comm_seq_pkg.sv
// fsc_pkg: shared types and helpers for the four-step commutation sequencer.
//   state_t    : sequencer state encoding {IDLE, S1, S2, S3}
//   mask_f/r   : forward (even-bit) / reverse (odd-bit) gate masks for nsw switches
//   vec_legal  : true when exactly one switch pair is 2'b11 and every other bit is 0
// Vectors are carried at MAXW bits inside the helpers; callers slice to 2*NSW.
package fsc_pkg;

  localparam int MAXW = 32;

  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;

  function automatic logic [MAXW-1:0] mask_f(input int nsw);
    mask_f = '0;
    for (int i = 0; i < MAXW/2; i++)
      if (i < nsw) mask_f[2*i] = 1'b1;
  endfunction

  function automatic logic [MAXW-1:0] mask_r(input int nsw);
    mask_r = '0;
    for (int i = 0; i < MAXW/2; i++)
      if (i < nsw) mask_r[2*i+1] = 1'b1;
  endfunction

  function automatic logic vec_legal(input logic [MAXW-1:0] v, input int nsw);
    int   ones;
    logic ok;
    ones = 0;
    ok   = 1'b1;
    for (int i = 0; i < MAXW/2; i++) begin
      if (i < nsw) begin
        // a half-on pair (only one gate of a switch) is never a legal target
        case (v[2*i +: 2])
          2'b11:   ones++;
          2'b00:   ;
          default: ok = 1'b0;
        endcase
      end else if (v[2*i +: 2] != 2'b00) begin
        ok = 1'b0;
      end
    end
    return ok && (ones == 1);
  endfunction

endpackage

// File: rtl/four_step_comm_seq_if.sv
// Handshake/bus bundle between the modulator (master) and the sequencer (slave).
//   vnew/dir/step_time/req/clr_fault : modulator -> sequencer
//   ready/busy/done/vout/fault       : sequencer -> modulator / gate drivers
interface four_step_comm_seq_if #(
  parameter int NSW    = 3,
  parameter int STEP_W = 8
);
  logic [2*NSW-1:0]  vnew;
  logic              dir;
  logic              req;
  logic [STEP_W-1:0] step_time;
  logic              clr_fault;
  logic              ready;
  logic              busy;
  logic              done;
  logic              fault;
  logic [2*NSW-1:0]  vout;

  modport master (output vnew, dir, req, step_time, clr_fault,
                  input  ready, busy, done, fault, vout);
  modport slave  (input  vnew, dir, req, step_time, clr_fault,
                  output ready, busy, done, fault, vout);
endinterface

// File: rtl/four_step_comm_seq_dwell_timer.sv
// fsc_dwell_timer: dwell counter for one sequencer step.
//   load   : restart at 0 (state entry), has priority
//   en     : count while a step is active
//   limit  : last count value (dwell - 1)
//   expire : count has reached limit; counter holds there (no wrap)
module fsc_dwell_timer #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic [STEP_W-1:0] limit,
  output logic              expire
);
  logic [STEP_W-1:0] cnt;

  assign expire = (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (load)            cnt <= '0;
    else if (en && !expire)   cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/four_step_comm_seq.sv
// four_step_comm_seq: four-step commutation sequencer for one output phase.
// Steps the gate vector from the last committed vector (vold) to an accepted
// target through current-direction-safe states S1..S3, each held step_q+1 cycles.
//   clk, rst_n : clock, async active-low reset (forces VRESET on vout)
//   bus        : four_step_comm_seq_if.slave (vnew/dir/req/step_time/clr_fault in,
//                ready/busy/done/fault/vout out)
// Optional: define FSC_VECTOR_CHECK_EN to reject illegal targets and raise a
// sticky fault; otherwise fault is tied 0 and clr_fault is ignored.
module four_step_comm_seq
  import fsc_pkg::*;
#(
  parameter int               NSW    = 3,
  parameter int               STEP_W = 8,
  parameter logic [2*NSW-1:0] VRESET = {{(2*NSW-2){1'b0}}, 2'b11}
) (
  input logic                 clk,
  input logic                 rst_n,
  four_step_comm_seq_if.slave bus
);
  localparam int               VW     = 2*NSW;
  localparam logic [MAXW-1:0]  MF_ALL = mask_f(NSW);
  localparam logic [MAXW-1:0]  MR_ALL = mask_r(NSW);
  localparam logic [VW-1:0]    MASK_F = MF_ALL[VW-1:0];
  localparam logic [VW-1:0]    MASK_R = MR_ALL[VW-1:0];

  state_t            state, state_nxt;
  logic [VW-1:0]     vold, vold_nxt, vnew_q, vout_q, vout_nxt;
  logic [VW-1:0]     nv, m;
  logic              dir_q, done_q, done_nxt;
  logic [STEP_W-1:0] step_q;
  logic              accept, legal, start, load, expire;

  assign accept = bus.req && (state == IDLE);

`ifdef FSC_VECTOR_CHECK_EN
  assign legal = vec_legal(MAXW'(bus.vnew), NSW);
`else
  assign legal = 1'b1;
`endif

  // an equal target completes the handshake without a sequence
  assign start = accept && legal && (bus.vnew != vold);

  fsc_dwell_timer #(.STEP_W(STEP_W)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .en     (state != IDLE),
    .limit  (step_q),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      vold   <= VRESET;
      vnew_q <= VRESET;
      vout_q <= VRESET;
      dir_q  <= 1'b0;
      step_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      vold   <= vold_nxt;
      vout_q <= vout_nxt;
      done_q <= done_nxt;
      if (start) begin
        vnew_q <= bus.vnew;
        dir_q  <= bus.dir;
        step_q <= bus.step_time;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    vold_nxt  = vold;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start)  begin state_nxt = S1; load = 1'b1; end
      S1:   if (expire) begin state_nxt = S2; load = 1'b1; end
      S2:   if (expire) begin state_nxt = S3; load = 1'b1; end
      S3:   if (expire) begin
              state_nxt = IDLE;
              vold_nxt  = vnew_q;
              done_nxt  = 1'b1;
            end
      default: state_nxt = IDLE;
    endcase

    // on the accepting edge the latched copies are not yet loaded
    nv = start ? bus.vnew : vnew_q;
    m  = (start ? bus.dir : dir_q) ? MASK_F : MASK_R;

    vout_nxt = vold_nxt;
    case (state_nxt)
      S1:      vout_nxt = vold & m;
      S2:      vout_nxt = (vold | nv) & m;
      S3:      vout_nxt = nv & m;
      default: vout_nxt = vold_nxt;
    endcase
  end

`ifdef FSC_VECTOR_CHECK_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= (accept && !legal) || (fault_q && !bus.clr_fault);
  end
  assign bus.fault = fault_q;
`else
  assign bus.fault = 1'b0;
`endif

  assign bus.ready = (state == IDLE);
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_q;
  assign bus.vout  = vout_q;
endmodule

// File: tb/tb_four_step_comm_seq.sv
module tb_four_step_comm_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  four_step_comm_seq_if #(.NSW(3), .STEP_W(8)) bus();

  four_step_comm_seq #(.NSW(3), .STEP_W(8), .VRESET(6'b000011)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [5:0]      vnew;
    logic            dir;
    logic            seq;
    logic [3:0][5:0] exp;   // vout for the 4 cycles after acceptance
  } vec_t;

  function automatic vec_t mk(input logic [5:0] v, input logic d, input logic s,
                              input logic [5:0] e0, e1, e2, e3);
    vec_t r;
    r.vnew = v; r.dir = d; r.seq = s;
    r.exp[0] = e0; r.exp[1] = e1; r.exp[2] = e2; r.exp[3] = e3;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act[7:0], exp[7:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[6];
    logic [5:0] e;
    // each row starts from the previous row's committed vector
    tbl[0] = mk(6'b001100, 1'b1, 1'b1, 6'b000001, 6'b000101, 6'b000100, 6'b001100);
    tbl[1] = mk(6'b110000, 1'b0, 1'b1, 6'b001000, 6'b101000, 6'b100000, 6'b110000);
    tbl[2] = mk(6'b000011, 1'b1, 1'b1, 6'b010000, 6'b010001, 6'b000001, 6'b000011);
    tbl[3] = mk(6'b001100, 1'b0, 1'b1, 6'b000010, 6'b001010, 6'b001000, 6'b001100);
    tbl[4] = mk(6'b001100, 1'b1, 1'b0, 6'b001100, 6'b001100, 6'b001100, 6'b001100);
    tbl[5] = mk(6'b000011, 1'b1, 1'b1, 6'b000100, 6'b000101, 6'b000001, 6'b000011);

    bus.req = 1'b0; bus.vnew = '0; bus.dir = 1'b0; bus.step_time = '0; bus.clr_fault = 1'b0;
    #2 rst_n = 1'b0;
    tick(); tick();
    chk("reset vout", 32'(bus.vout), 32'b000011);
    chk("reset ready", 32'(bus.ready), 1);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset done", 32'(bus.done), 0);
    chk("reset fault", 32'(bus.fault), 0);
    rst_n = 1'b1;
    tick();

    // table-driven single commutations, step_time = 0
    for (int i = 0; i < 6; i++) begin
      bus.vnew = tbl[i].vnew; bus.dir = tbl[i].dir; bus.step_time = 8'd0; bus.req = 1'b1;
      chk($sformatf("v%0d ready", i), 32'(bus.ready), 1);
      tick();
      bus.req = 1'b0;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("v%0d c%0d vout", i, k+1), 32'(bus.vout), 32'(tbl[i].exp[k]));
        chk($sformatf("v%0d c%0d done", i, k+1), 32'(bus.done), 32'(tbl[i].seq && k == 3));
        chk($sformatf("v%0d c%0d busy", i, k+1), 32'(bus.busy), 32'(tbl[i].seq && k < 3));
        if (k < 3) tick();
      end
      tick();
    end

    // step_time = 3: each step held 4 cycles, done 13 cycles after acceptance
    bus.vnew = 6'b001100; bus.dir = 1'b1; bus.step_time = 8'd3; bus.req = 1'b1;
    tick();
    bus.req = 1'b0; bus.step_time = 8'd0;
    for (int c = 1; c <= 13; c++) begin
      e = (c <= 4) ? 6'b000001 : (c <= 8) ? 6'b000101 : (c <= 12) ? 6'b000100 : 6'b001100;
      chk($sformatf("dwell c%0d vout", c), 32'(bus.vout), 32'(e));
      chk($sformatf("dwell c%0d done", c), 32'(bus.done), 32'(c == 13));
      if (c < 13) tick();
    end
    tick();

    // back-to-back: second request held during busy, mid-sequence input changes ignored
    bus.vnew = 6'b110000; bus.dir = 1'b0; bus.req = 1'b1;
    tick();
    bus.vnew = 6'b000011; bus.dir = 1'b1;
    chk("b2b c1 vout", 32'(bus.vout), 32'b001000);
    chk("b2b c1 ready", 32'(bus.ready), 0);
    tick();
    chk("b2b c2 vout", 32'(bus.vout), 32'b101000);
    tick();
    chk("b2b c3 vout", 32'(bus.vout), 32'b100000);
    tick();
    chk("b2b c4 vout", 32'(bus.vout), 32'b110000);
    chk("b2b c4 done", 32'(bus.done), 1);
    chk("b2b c4 ready", 32'(bus.ready), 1);
    tick();
    bus.req = 1'b0;
    chk("b2b c5 vout", 32'(bus.vout), 32'b010000);
    chk("b2b c5 busy", 32'(bus.busy), 1);
    chk("b2b c5 done", 32'(bus.done), 0);
    tick();
    chk("b2b c6 vout", 32'(bus.vout), 32'b010001);
    tick();
    chk("b2b c7 vout", 32'(bus.vout), 32'b000001);
    tick();
    chk("b2b c8 vout", 32'(bus.vout), 32'b000011);
    chk("b2b c8 done", 32'(bus.done), 1);
    tick();

    // reset during S2 aborts immediately
    bus.vnew = 6'b001100; bus.dir = 1'b1; bus.req = 1'b1;
    tick();
    bus.req = 1'b0;
    tick();
    chk("rst S2 vout", 32'(bus.vout), 32'b000101);
    rst_n = 1'b0;
    #1;
    chk("rst async vout", 32'(bus.vout), 32'b000011);
    chk("rst async ready", 32'(bus.ready), 1);
    chk("rst async done", 32'(bus.done), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst after vout", 32'(bus.vout), 32'b000011);
    chk("rst after busy", 32'(bus.busy), 0);

    // illegal vector
    bus.vnew = 6'b000111; bus.dir = 1'b1; bus.req = 1'b1;
    chk("ill ready", 32'(bus.ready), 1);
    tick();
    bus.req = 1'b0;
`ifdef FSC_VECTOR_CHECK_EN
    chk("ill fault", 32'(bus.fault), 1);
    chk("ill vout", 32'(bus.vout), 32'b000011);
    chk("ill busy", 32'(bus.busy), 0);
    tick();
    chk("ill sticky", 32'(bus.fault), 1);
    bus.clr_fault = 1'b1;
    tick();
    bus.clr_fault = 1'b0;
    chk("ill cleared", 32'(bus.fault), 0);
    chk("ill vout kept", 32'(bus.vout), 32'b000011);
`else
    chk("ill nocheck fault", 32'(bus.fault), 0);
    chk("ill nocheck busy", 32'(bus.busy), 1);
    chk("ill nocheck vout", 32'(bus.vout), 32'b000001);
    tick(); tick(); tick();
    chk("ill nocheck commit", 32'(bus.vout), 32'b000111);
    bus.clr_fault = 1'b1;
    tick();
    bus.clr_fault = 1'b0;
    chk("ill nocheck fault2", 32'(bus.fault), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
